compare_block: RTL and testbench
================================

Name: compare_block

Overview:
- Sits directly downstream of transmitter_block in the memory checker.
- Queues one expected-data descriptor per read command issued on the Avalon-MM master, then checks every returned readdata word against the regenerated write pattern, comparing enabled bytes only.
- On the first failure it raises the sticky error_check_o, which stalls the transmitter, and freezes diagnostic capture registers for CSR readout.

Parameters:
- CMP_FIFO_DEPTH, 8, descriptor queue depth (power of two, at least 2).
- AMM_DATA_W, AMM_BURST_W, ADDR_W, BYTE_PER_WORD: taken from settings_pkg, not overridable.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- test_start_i  in  1  one-cycle pulse: clears error state, counters and FIFO
- cmp_pkt_en_i  in  1  descriptor push strobe from transmitter
- cmp_pkt_struct_i  in  pkt_struct_type  word_address, burst_word_count (words-1), start_mask, end_mask, data_ptrn_type, data_ptrn[7:0]
- readdatavalid_i  in  1  Avalon-MM read data valid
- readdata_i  in  AMM_DATA_W  Avalon-MM read data
- error_check_o  out  1  sticky error flag, to transmitter
- err_code_o  out  2  cmp_err_type: NO_ERR=0, DATA_MISMATCH=1, FIFO_OVF=2, UNEXP_DATA=3
- err_word_addr_o  out  ADDR_W  word address of the failing word
- err_readdata_o  out  AMM_DATA_W  captured read word
- err_expected_o  out  AMM_DATA_W  expected word, masked bytes forced to 0
- words_checked_o  out  32  saturating count of compared words
- cmp_busy_o  out  1  FIFO non-empty or pipeline holds a word

Behaviour:
- Reset (rst_i high at a clock edge) sets every output to 0 and empties the FIFO. test_start_i has the same effect, except it does not touch the LFSR register.
- FIFO is show-ahead: the head is valid the cycle after the push.
  - A push and a pop in the same cycle while full is legal and does not count as overflow.
  - A push while full, with no pop, drops the descriptor and raises the FIFO_OVF error.
- Current burst is the FIFO head. word_idx counts from 0 to burst_word_count. Each readdatavalid_i advances word_idx. On the last word the head is popped and word_idx returns to 0, so back-to-back bursts run with no bubble.
- Expected pattern, one byte replicated across all BYTE_PER_WORD lanes:
  - FIX (data_ptrn_type=0): the byte is data_ptrn.
  - RND (data_ptrn_type=1): the byte is seed=data_ptrn when word_idx==0, otherwise lfsr_reg. lfsr_reg updates each word to {cur[6:0], cur[6]^cur[1]^cur[0]}.
- Byte mask per word:
  - single-word burst: start_mask & end_mask
  - word_idx 0: start_mask
  - last word: end_mask
  - middle words: all ones
- Pipeline and latency:
  - Stage 1 (N+1) registers readdata, expected word, mask and address (word_address + word_idx, wraps modulo 2^ADDR_W).
  - Stage 2 compares the masked bytes. On a mismatch, error_check_o rises at N+2, where N is the readdatavalid_i cycle.
- words_checked_o increments at stage 2 for every compared word, saturating at 32'hFFFF_FFFF.
- readdatavalid_i with the FIFO empty, including the cycle of a simultaneous push, raises the UNEXP_DATA error. err_readdata_o captures the word; address and expected are 0.
- Error capture is first-error-only. When two errors occur in the same cycle, priority is DATA_MISMATCH > UNEXP_DATA > FIFO_OVF.
- After an error:
  - pushes and read data are ignored and the counter freezes;
  - outputs hold until test_start_i;
  - the FIFO keeps its content until test_start_i flushes it.
- test_start_i in the same cycle as readdatavalid_i: the flush wins and the word is discarded.
- Reset mid-burst discards the partial burst with no error.
- cmp_busy_o = FIFO non-empty OR stage 1 valid OR stage 2 valid, registered.

Decomposition:
- settings_pkg holds:
  - pkt_struct_type and cmp_err_type enum
  - data_mode_type (FIX_DATA/RND_DATA)
  - lfsr_next function, shared with transmitter_block so both sides use one polynomial
  - byte_mask_func
- Sub-module cmp_desc_fifo: synchronous show-ahead FIFO of pkt_struct_type with push, pop, full, empty and flush.
- Checker FSM, LFSR, pipeline and capture logic live in compare_block.

Test Plan (BYTE_PER_WORD=4, AMM_DATA_W=32):
- FIX pattern, addr=0x10, burst_word_count=3, masks all 1, data_ptrn=0xA5; four words 0xA5A5A5A5 -> error_check_o stays 0, words_checked_o=4, cmp_busy_o falls 3 cycles after the last word.
- RND pattern, seed 0xFF, burst of 3; return LFSR(0xFF)^k per word, then corrupt word 2 -> error_check_o=1 at N+2, err_code_o=1, err_word_addr_o=base+2, err_expected_o=expected word.
- Single word, start_mask=4'b1100, end_mask=4'b0111, FIX 0x3C; readdata 0xFF3CFFFF -> pass (only byte 2 compared); 0xFF00FFFF -> DATA_MISMATCH, err_expected_o=0x003C0000.
- Push 9 descriptors with no read data and depth 8 -> FIFO_OVF on the 9th; full push with a simultaneous pop -> no error.
- readdatavalid_i with the FIFO empty, readdata 0x12345678 -> err_code_o=3, err_readdata_o=0x12345678; then test_start_i -> all error outputs 0 next cycle.
- Two back-to-back bursts of 2 words each (RND seeds 0x01 and 0x80), valid every cycle -> no bubble, no error, words_checked_o=4.

Source files
------------

// File: rtl/settings_pkg.sv
// Shared memory-checker settings: bus geometry, descriptor layout, error codes
// and the pattern helpers that both the transmitter and the comparator use.
package settings_pkg;

    localparam int AMM_DATA_W    = 32;
    localparam int AMM_BURST_W   = 8;
    localparam int ADDR_W        = 24;
    localparam int BYTE_PER_WORD = AMM_DATA_W / 8;

    typedef enum logic {
        FIX_DATA = 1'b0,
        RND_DATA = 1'b1
    } data_mode_type;

    typedef enum logic [1:0] {
        NO_ERR        = 2'd0,
        DATA_MISMATCH = 2'd1,
        FIFO_OVF      = 2'd2,
        UNEXP_DATA    = 2'd3
    } cmp_err_type;

    typedef struct packed {
        logic [ADDR_W-1:0]        word_address;
        logic [AMM_BURST_W-1:0]   burst_word_count;
        logic [BYTE_PER_WORD-1:0] start_mask;
        logic [BYTE_PER_WORD-1:0] end_mask;
        data_mode_type            data_ptrn_type;
        logic [7:0]               data_ptrn;
    } pkt_struct_type;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[6] ^ cur[1] ^ cur[0]};
    endfunction

    function automatic logic [BYTE_PER_WORD-1:0] byte_mask_func(
        input logic [AMM_BURST_W-1:0]   word_idx,
        input logic [AMM_BURST_W-1:0]   word_cnt,
        input logic [BYTE_PER_WORD-1:0] start_mask,
        input logic [BYTE_PER_WORD-1:0] end_mask
    );
        if (word_cnt == '0)            return start_mask & end_mask;
        else if (word_idx == '0)       return start_mask;
        else if (word_idx == word_cnt) return end_mask;
        return '1;
    endfunction

endpackage

// File: rtl/compare_block_fifo.sv
// Show-ahead descriptor FIFO: the head is readable the cycle after the push.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module cmp_desc_fifo
    import settings_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  pkt_struct_type din_i,
    output pkt_struct_type dout_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;
    pkt_struct_type   mem [DEPTH];

    assign full_o  = (count == (PTR_W+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage carries no reset; entries are only read behind the
    // count/pointers, so clearing it would just cost a reset net per bit.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/compare_block.sv
// Read-data checker: walks each queued burst descriptor, regenerates the write
// pattern per word and compares enabled bytes; first error is captured and held.
module compare_block
    import settings_pkg::*;
#(
    parameter int CMP_FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_start_i,
    input  logic                  cmp_pkt_en_i,
    input  pkt_struct_type        cmp_pkt_struct_i,
    input  logic                  readdatavalid_i,
    input  logic [AMM_DATA_W-1:0] readdata_i,
    output logic                  error_check_o,
    output cmp_err_type           err_code_o,
    output logic [ADDR_W-1:0]     err_word_addr_o,
    output logic [AMM_DATA_W-1:0] err_readdata_o,
    output logic [AMM_DATA_W-1:0] err_expected_o,
    output logic [31:0]           words_checked_o,
    output logic                  cmp_busy_o
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } chk_state_t;

    chk_state_t               state_q, state_d;
    pkt_struct_type           head;
    logic                     fifo_full, fifo_empty;
    logic                     running, last_word, accept, pop, push;
    logic                     unexp, ovf, mismatch;
    cmp_err_type              err_sel;
    logic [AMM_BURST_W-1:0]   word_idx;
    logic [7:0]               lfsr_reg, cur_byte;
    logic [BYTE_PER_WORD-1:0] cur_mask;

    logic                     s1_valid, s2_valid;
    logic [AMM_DATA_W-1:0]    s1_data, s1_exp, s1_mask_bits;
    logic [BYTE_PER_WORD-1:0] s1_mask;
    logic [ADDR_W-1:0]        s1_addr;

    cmp_desc_fifo #(.DEPTH(CMP_FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (test_start_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (cmp_pkt_struct_i),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the process can leave one unassigned and infer a latch.
    always_comb begin
        running   = (state_q == ST_RUN);
        last_word = (word_idx == head.burst_word_count);
        cur_byte  = (head.data_ptrn_type == RND_DATA && word_idx != '0) ? lfsr_reg
                                                                         : head.data_ptrn;
        cur_mask  = byte_mask_func(word_idx, head.burst_word_count,
                                   head.start_mask, head.end_mask);
        accept    = readdatavalid_i & running & ~test_start_i & ~fifo_empty;
        unexp     = readdatavalid_i & running & ~test_start_i &  fifo_empty;
        pop       = accept & last_word;
        push      = cmp_pkt_en_i & running & ~test_start_i;
        ovf       = push & fifo_full & ~pop;

        s1_mask_bits = '0;
        for (int i = 0; i < BYTE_PER_WORD; i++) begin
            s1_mask_bits[8*i +: 8] = {8{s1_mask[i]}};
        end
        mismatch = running & s1_valid & (|((s1_data ^ s1_exp) & s1_mask_bits));

        if (mismatch)   err_sel = DATA_MISMATCH;
        else if (unexp) err_sel = UNEXP_DATA;
        else if (ovf)   err_sel = FIFO_OVF;
        else            err_sel = NO_ERR;
    end

    always_comb begin
        state_d       = state_q;
        error_check_o = (state_q == ST_ERR);
        if (test_start_i)                              state_d = ST_RUN;
        else if (state_q == ST_RUN && err_sel != NO_ERR) state_d = ST_ERR;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // The LFSR survives test_start so a new test can continue the sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i)       lfsr_reg <= '0;
        else if (accept) lfsr_reg <= lfsr_next(cur_byte);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || test_start_i) begin
            word_idx        <= '0;
            s1_valid        <= 1'b0;
            s1_data         <= '0;
            s1_exp          <= '0;
            s1_mask         <= '0;
            s1_addr         <= '0;
            s2_valid        <= 1'b0;
            words_checked_o <= '0;
            cmp_busy_o      <= 1'b0;
            err_code_o      <= NO_ERR;
            err_word_addr_o <= '0;
            err_readdata_o  <= '0;
            err_expected_o  <= '0;
        end else begin
            s1_valid   <= accept;
            s2_valid   <= s1_valid;
            cmp_busy_o <= ~fifo_empty | s1_valid | s2_valid;
            if (accept) begin
                word_idx <= last_word ? '0 : word_idx + AMM_BURST_W'(1);
                s1_data  <= readdata_i;
                s1_exp   <= {BYTE_PER_WORD{cur_byte}};
                s1_mask  <= cur_mask;
                s1_addr  <= head.word_address + ADDR_W'(word_idx);
            end
            if (running && s1_valid && words_checked_o != 32'hFFFF_FFFF)
                words_checked_o <= words_checked_o + 32'd1;
            if (running && err_sel != NO_ERR) begin
                err_code_o <= err_sel;
                if (err_sel == DATA_MISMATCH) begin
                    err_word_addr_o <= s1_addr;
                    err_readdata_o  <= s1_data;
                    err_expected_o  <= s1_exp & s1_mask_bits;
                end else if (err_sel == UNEXP_DATA) begin
                    err_readdata_o  <= readdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_block.sv
// Directed bench for compare_block: stimulus queues expected output events,
// a negedge monitor pops one per observed change of error/word-count outputs.
module tb_compare_block;
    import settings_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  test_start;
    logic                  cmp_pkt_en;
    pkt_struct_type        pkt;
    logic                  rdv;
    logic [AMM_DATA_W-1:0] readdata;
    logic                  error_check;
    cmp_err_type           err_code;
    logic [ADDR_W-1:0]     err_word_addr;
    logic [AMM_DATA_W-1:0] err_readdata;
    logic [AMM_DATA_W-1:0] err_expected;
    logic [31:0]           words_checked;
    logic                  cmp_busy;

    compare_block #(.CMP_FIFO_DEPTH(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .test_start_i     (test_start),
        .cmp_pkt_en_i     (cmp_pkt_en),
        .cmp_pkt_struct_i (pkt),
        .readdatavalid_i  (rdv),
        .readdata_i       (readdata),
        .error_check_o    (error_check),
        .err_code_o       (err_code),
        .err_word_addr_o  (err_word_addr),
        .err_readdata_o   (err_readdata),
        .err_expected_o   (err_expected),
        .words_checked_o  (words_checked),
        .cmp_busy_o       (cmp_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic        err;
        logic [1:0]  code;
        logic [23:0] addr;
        logic [31:0] rd;
        logic [31:0] ex;
        logic [31:0] wc;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          fails  = 0;
    logic        mon_en = 1'b0;
    logic        prev_err;
    logic [31:0] prev_wc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cmp_pkt_en = 1'b0;
        rdv        = 1'b0;
        test_start = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic expect_ev(input string tag, input logic err, input logic [1:0] code,
                             input logic [23:0] addr, input logic [31:0] rd,
                             input logic [31:0] ex, input logic [31:0] wc, input int off);
        exp_t x;
        x.tag = tag; x.err = err; x.code = code; x.addr = addr;
        x.rd = rd; x.ex = ex; x.wc = wc; x.at = cyc + off;
        sb.push_back(x);
    endtask

    task automatic set_desc(input logic [23:0] a, input logic [7:0] bwc, input logic [3:0] sm,
                            input logic [3:0] em, input data_mode_type m, input logic [7:0] p);
        pkt.word_address     = a;
        pkt.burst_word_count = bwc;
        pkt.start_mask       = sm;
        pkt.end_mask         = em;
        pkt.data_ptrn_type   = m;
        pkt.data_ptrn        = p;
        cmp_pkt_en           = 1'b1;
    endtask

    task automatic push_desc(input logic [23:0] a, input logic [7:0] bwc, input logic [3:0] sm,
                             input logic [3:0] em, input data_mode_type m, input logic [7:0] p);
        set_desc(a, bwc, sm, em, m, p);
        step();
    endtask

    task automatic send_word(input logic [31:0] d);
        rdv      = 1'b1;
        readdata = d;
        step();
    endtask

    task automatic clear_test(input string tag);
        expect_ev(tag, 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'h0, 1);
        test_start = 1'b1;
        step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (error_check !== prev_err || words_checked !== prev_wc) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event: err=%0b words=%0d at cycle %0d, none expected",
                             error_check, words_checked, cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_err"},   64'(error_check),   64'(e.err));
                    check({e.tag, "_code"},  64'(err_code),      64'(e.code));
                    check({e.tag, "_addr"},  64'(err_word_addr), 64'(e.addr));
                    check({e.tag, "_rdata"}, 64'(err_readdata),  64'(e.rd));
                    check({e.tag, "_exp"},   64'(err_expected),  64'(e.ex));
                    check({e.tag, "_words"}, 64'(words_checked), 64'(e.wc));
                    check({e.tag, "_cycle"}, 64'(cyc),           64'(e.at));
                end
            end
            prev_err = error_check;
            prev_wc  = words_checked;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; test_start = 1'b0; cmp_pkt_en = 1'b0; rdv = 1'b0;
        readdata = '0; pkt = '0;
        @(negedge clk); @(negedge clk);
        check("rst_err",   64'(error_check),   64'd0);
        check("rst_code",  64'(err_code),      64'd0);
        check("rst_addr",  64'(err_word_addr), 64'd0);
        check("rst_rdata", 64'(err_readdata),  64'd0);
        check("rst_exp",   64'(err_expected),  64'd0);
        check("rst_words", 64'(words_checked), 64'd0);
        check("rst_busy",  64'(cmp_busy),      64'd0);
        prev_err = error_check;
        prev_wc  = words_checked;
        mon_en   = 1'b1;
        rst      = 1'b0;
        step();

        // FIX burst of four, all bytes enabled
        push_desc(24'h10, 8'd3, 4'hF, 4'hF, FIX_DATA, 8'hA5);
        for (int k = 1; k <= 4; k++) begin
            expect_ev("fix_word", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'(k), 2);
            send_word(32'hA5A5_A5A5);
        end
        step(); step();
        check("fix_busy_tail", 64'(cmp_busy), 64'd1);
        step();
        check("fix_busy_fall", 64'(cmp_busy), 64'd0);

        // RND seed 0xFF (fixed point of the LFSR), third word corrupted
        push_desc(24'h100, 8'd2, 4'hF, 4'hF, RND_DATA, 8'hFF);
        expect_ev("rnd_w0", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd5, 2);
        send_word(32'hFFFF_FFFF);
        expect_ev("rnd_w1", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd6, 2);
        send_word(32'hFFFF_FFFF);
        expect_ev("rnd_mis", 1'b1, 2'd1, 24'h102, 32'hFFFF_00FF, 32'hFFFF_FFFF, 32'd7, 2);
        send_word(32'hFFFF_00FF);
        step(); step();
        push_desc(24'h200, 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h00);
        send_word(32'h0000_0001);
        step(); step();
        check("hold_err",   64'(error_check),   64'd1);
        check("hold_words", 64'(words_checked), 64'd7);
        clear_test("clr_rnd");
        step();

        // Single word with partial masks: only byte 2 is compared
        push_desc(24'h20, 8'd0, 4'b1100, 4'b0111, FIX_DATA, 8'h3C);
        expect_ev("msk_pass", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd1, 2);
        send_word(32'hFF3C_FFFF);
        push_desc(24'h20, 8'd0, 4'b1100, 4'b0111, FIX_DATA, 8'h3C);
        expect_ev("msk_fail", 1'b1, 2'd1, 24'h20, 32'hFF00_FFFF, 32'h003C_0000, 32'd2, 2);
        send_word(32'hFF00_FFFF);
        step(); step();
        clear_test("clr_msk");
        step();

        // Ninth push into a depth-8 FIFO overflows
        for (int i = 0; i < 8; i++) push_desc(24'(i), 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h00);
        expect_ev("ovf", 1'b1, 2'd2, 24'h0, 32'h0, 32'h0, 32'd0, 1);
        push_desc(24'h8, 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h00);
        step();
        clear_test("clr_ovf");

        // Full FIFO: push with a simultaneous pop is not an overflow
        for (int i = 0; i < 8; i++) push_desc(24'(i), 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h00);
        expect_ev("full_pushpop", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd1, 2);
        set_desc(24'h9, 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h00);
        rdv = 1'b1; readdata = 32'h0;
        step();
        step(); step();
        check("full_pushpop_noerr", 64'(error_check), 64'd0);
        clear_test("clr_full");
        step();

        // Read data with nothing queued
        expect_ev("unexp", 1'b1, 2'd3, 24'h0, 32'h1234_5678, 32'h0, 32'd0, 1);
        send_word(32'h1234_5678);
        step();
        clear_test("clr_unexp");
        check("unexp_clr_code",  64'(err_code),     64'd0);
        check("unexp_clr_rdata", 64'(err_readdata), 64'd0);

        // Back-to-back RND bursts: 01,03 then 80,00
        push_desc(24'h40, 8'd1, 4'hF, 4'hF, RND_DATA, 8'h01);
        push_desc(24'h50, 8'd1, 4'hF, 4'hF, RND_DATA, 8'h80);
        expect_ev("b2b_w1", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd1, 2);
        send_word(32'h0101_0101);
        expect_ev("b2b_w2", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd2, 2);
        send_word(32'h0303_0303);
        expect_ev("b2b_w3", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd3, 2);
        send_word(32'h8080_8080);
        expect_ev("b2b_w4", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd4, 2);
        send_word(32'h0000_0000);
        step(); step(); step();

        // Reset in the middle of a burst discards it silently
        push_desc(24'h0, 8'd3, 4'hF, 4'hF, FIX_DATA, 8'h55);
        expect_ev("pre_rst_w1", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd5, 2);
        send_word(32'h5555_5555);
        expect_ev("pre_rst_w2", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd6, 2);
        send_word(32'h5555_5555);
        step(); step();
        expect_ev("mid_rst", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd0, 1);
        rst = 1'b1;
        step();
        push_desc(24'h0, 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h11);
        expect_ev("post_rst", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd1, 2);
        send_word(32'h1111_1111);
        step(); step(); step();

        // test_start together with read data: the flush wins
        push_desc(24'h0, 8'd0, 4'hF, 4'hF, FIX_DATA, 8'h22);
        expect_ev("flush", 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 32'd0, 1);
        test_start = 1'b1; rdv = 1'b1; readdata = 32'h2222_2222;
        step();
        step(); step(); step();
        expect_ev("post_flush_unexp", 1'b1, 2'd3, 24'h0, 32'h3333_3333, 32'h0, 32'd0, 1);
        send_word(32'h3333_3333);
        step();
        clear_test("clr_final");

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
